// File: rtl/cache_controller.sv
// Control FSM sequencing the cache datapath: hit service, dirty-victim writeback and line fill.
// Optional hit/miss/writeback counters are enabled by defining CACHE_CTRL_PERF_COUNTERS_EN.
module cache_controller #(
    parameter bit          READ_ONLY      = 1'b0,
    parameter int unsigned WORDS_PER_LINE = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_store,
    output logic        req_fulfilled,
    output logic        hmem_req_valid,
    output logic        hmem_req_store,
    input  logic        hmem_req_fulfilled,
    input  logic        valid_block_match,
    input  logic        valid_dirty_bit,
    input  logic        counter_done,
    output logic        miss_recovery_mode,
    output logic        clear_selected_dirty_bit,
    output logic        set_selected_dirty_bit,
    output logic        perform_write,
    output logic        clear_selected_valid_bit,
    output logic        finish_new_line_install,
    output logic        set_hmem_block_address,
    output logic        use_victim_tag_for_hmem_block_address,
    output logic        reset_counter,
`ifdef CACHE_CTRL_PERF_COUNTERS_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [31:0] writeback_count,
`endif
    output logic        decrement_counter
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_t;

    localparam bit WB_EN = !READ_ONLY;
    localparam int unsigned BEAT_W = $clog2(WORDS_PER_LINE + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

    state_t state_reg;
    state_t state_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Outputs are decoded from state and live inputs so a hit completes in the request cycle.
    always_comb begin
        state_next                            = state_reg;
        req_fulfilled                         = 1'b0;
        hmem_req_valid                        = 1'b0;
        hmem_req_store                        = 1'b0;
        miss_recovery_mode                    = 1'b0;
        clear_selected_dirty_bit              = 1'b0;
        set_selected_dirty_bit                = 1'b0;
        perform_write                         = 1'b0;
        clear_selected_valid_bit              = 1'b0;
        finish_new_line_install               = 1'b0;
        set_hmem_block_address                = 1'b0;
        use_victim_tag_for_hmem_block_address = 1'b0;
        reset_counter                         = 1'b0;
        decrement_counter                     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (valid_block_match) begin
                        req_fulfilled = 1'b1;
                        if (WB_EN && req_store) begin
                            perform_write          = 1'b1;
                            set_selected_dirty_bit = 1'b1;
                        end
                    end else begin
                        set_hmem_block_address = 1'b1;
                        reset_counter          = 1'b1;
                        if (WB_EN && valid_dirty_bit) begin
                            use_victim_tag_for_hmem_block_address = 1'b1;
                            state_next = WRITEBACK;
                        end else begin
                            state_next = FETCH;
                        end
                    end
                end
            end
            WRITEBACK: begin
                miss_recovery_mode = 1'b1;
                hmem_req_valid     = 1'b1;
                hmem_req_store     = 1'b1;
                if (hmem_req_fulfilled) begin
                    if (!counter_done) begin
                        decrement_counter = 1'b1;
                    end else begin
                        // Victim is out; retarget the block address at the requested line.
                        clear_selected_dirty_bit = WB_EN;
                        set_hmem_block_address   = 1'b1;
                        reset_counter            = 1'b1;
                        state_next               = FETCH;
                    end
                end
            end
            FETCH: begin
                miss_recovery_mode       = 1'b1;
                hmem_req_valid           = 1'b1;
                clear_selected_valid_bit = 1'b1;
                if (hmem_req_fulfilled) begin
                    perform_write = 1'b1;
                    if (!counter_done) begin
                        decrement_counter = 1'b1;
                    end else begin
                        finish_new_line_install = 1'b1;
                        state_next              = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Beats moved in the current transfer phase; only used to bound line length in assertions.
    logic [BEAT_W-1:0] beat_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_reg <= '0;
        end else if (reset_counter) begin
            beat_reg <= '0;
        end else if (hmem_req_valid && hmem_req_fulfilled) begin
            beat_reg <= beat_reg + BEAT_W'(1);
        end
    end

    a_no_reset_and_decrement: assert property (
        @(posedge clk) disable iff (reset) !(decrement_counter && reset_counter));

    a_line_length: assert property (
        @(posedge clk) disable iff (reset)
        (hmem_req_valid && hmem_req_fulfilled) |-> (beat_reg <= LAST_BEAT));

`ifdef CACHE_CTRL_PERF_COUNTERS_EN
    logic [2:0]  perf_event;
    logic [31:0] perf_count [3];

    assign perf_event[0] = (state_reg == IDLE) && req_valid && valid_block_match;
    assign perf_event[1] = (state_reg == IDLE) && req_valid && !valid_block_match;
    assign perf_event[2] = (state_reg == WRITEBACK) && hmem_req_fulfilled && counter_done;

    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
        logic [31:0] count_reg;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                count_reg <= '0;
            end else if (perf_event[gi] && (count_reg != '1)) begin
                count_reg <= count_reg + 32'd1;
            end
        end

        assign perf_count[gi] = count_reg;
    end

    assign hit_count       = perf_count[0];
    assign miss_count      = perf_count[1];
    assign writeback_count = perf_count[2];
`endif

endmodule
